// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read at a
// time and holds the fetched word for decode under a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

  // Handshake: decode takes Instr/PC in any cycle where InstrValid & InstrReady;
  // InstrValid never drops without a transfer except on Redirect or reset.
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        kill, kill_next;
  logic [31:0] instr_next, pc_next;
  logic        valid_next;
  logic [31:0] redirect_pc;

  assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      kill       <= 1'b0;
      Instr      <= 32'h0;
      PC         <= 32'h0;
      InstrValid <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      kill       <= kill_next;
      Instr      <= instr_next;
      PC         <= pc_next;
      InstrValid <= valid_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    kill_next     = kill;
    instr_next    = Instr;
    pc_next       = PC;
    valid_next    = InstrValid;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        state_next = WAIT;
        if (Redirect) kill_next = 1'b1;
      end
      WAIT: begin
        if (imem_rvalid) begin
          // A response is dropped if it was killed earlier or a redirect lands now.
          if (kill || Redirect) begin
            kill_next  = 1'b0;
            state_next = FETCH;
          end else begin
            instr_next    = imem_rdata;
            pc_next       = fetch_pc;
            valid_next    = 1'b1;
            fetch_pc_next = fetch_pc + 32'd4;
            state_next    = HOLD;
          end
        end else if (Redirect) begin
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (Redirect || InstrReady) begin
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
    if (Redirect) fetch_pc_next = redirect_pc;
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = imem_req ? fetch_pc : 32'h0;
  assign Op        = Instr[31:26];
  assign Funct     = Instr[5:0];
  assign PCPlus4   = PC + 32'd4;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS datapath. It owns the program counter, issues one word read at a time to instruction memory, and presents the fetched word to decode with a valid/ready handshake. `Op` and `Funct` are split out for the control unit. Branch resolution downstream redirects the PC through `Redirect`/`RedirectPC`, and any fetch already in flight is discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Must be word-aligned.
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  read request, one-cycle pulse
- `imem_addr`  out  32  byte address of the request, always word-aligned
- `imem_rvalid`  in  1  read data valid, exactly one pulse per request, ≥1 cycle after the request
- `imem_rdata`  in  32  instruction word, sampled when `imem_rvalid`
- `Instr`  out  32  held instruction
- `Op`  out  6  `Instr[31:26]`
- `Funct`  out  6  `Instr[5:0]`
- `PC`  out  32  address of `Instr`
- `PCPlus4`  out  32  `PC + 4`, modulo 2^32
- `InstrValid`  out  1  `Instr`/`PC` valid for decode
- `InstrReady`  in  1  decode accepts; transfer occurs when `InstrValid & InstrReady`
- `Redirect`  in  1  branch/jump taken, one-cycle pulse
- `RedirectPC`  in  32  target; bits [1:0] forced to 00

## Operation
- Registers: `state`, `fetch_pc`, `kill` (in-flight response must be dropped), `Instr`, `PC`, `InstrValid`.
- Reset values:
  - `state` = IDLE, `fetch_pc` = `RESET_PC`, `kill` = 0.
  - `Instr` = 0, `PC` = 0, `InstrValid` = 0, `imem_req` = 0, `imem_addr` = 0.
  - `PCPlus4` = 4, `Op`/`Funct` = 0.
- Only one outstanding request at a time.
- FSM states:
  - IDLE: always moves to FETCH next cycle.
  - FETCH: `imem_req` = 1 and `imem_addr` = `fetch_pc` for exactly this cycle; moves to WAIT.
  - WAIT: waits for `imem_rvalid`.
    - `kill` = 1: discard data, clear `kill`, go to FETCH.
    - `kill` = 0: latch `Instr` ← `imem_rdata`, `PC` ← `fetch_pc`, set `InstrValid`, set `fetch_pc` ← `fetch_pc` + 4 (wraps 0xFFFF_FFFC → 0), go to HOLD.
  - HOLD: `InstrValid` = 1 and `Instr`/`PC` stable. On `InstrReady`, `InstrValid` ← 0 and go to FETCH.
- Redirect has priority over everything except reset. It sets `fetch_pc` ← {`RedirectPC`[31:2], 2'b00}. Effect by state:
  - IDLE: go to FETCH.
  - FETCH: the request still issues; set `kill`, go to WAIT.
  - WAIT without `imem_rvalid`: set `kill`, stay in WAIT.
  - WAIT with `imem_rvalid` in the same cycle: discard data, `kill` = 0, go to FETCH.
  - HOLD: `InstrValid` ← 0, go to FETCH. If `InstrReady` is high in the same cycle, the transfer counts as completed.
- `imem_rvalid` outside WAIT is ignored.
- Reset asserted mid-operation returns all registers to reset values next edge. A stale response arriving afterwards is ignored because `state` ≠ WAIT.

## Timing
- Cycle 0 is the first cycle with `reset` low. Memory latency L is the number of cycles from request to `imem_rvalid`, L ≥ 1.
- Cycle 0 is IDLE; cycle 1 is FETCH with `imem_addr` = `RESET_PC`. `imem_rvalid` arrives in cycle 1+L, and `InstrValid` = 1 from cycle 2+L.
- With `InstrReady` tied high and L = 1, the sequence is FETCH/WAIT/HOLD: one instruction every 3 cycles, with `imem_req` every 3rd cycle.
- After a transfer in cycle n, the next request is in cycle n+1 at the old `PC` + 4.
- After a redirect in cycle n, the request for `RedirectPC` is in cycle n+1 from IDLE or HOLD. From FETCH or WAIT, it is in the cycle after the killed response.
- `Op`, `Funct` and `PCPlus4` are combinational from registers and change only at the edge where `Instr`/`PC` load.

## Test plan
- Reset/sequential: `RESET_PC` = 0, L = 1, memory returns 0x0109_5020 then 0x8C08_0004, `InstrReady` = 1.
  - `imem_addr` = 0 in cycle 1, then 4 in cycle 4.
  - First transfer: `Op` = 000000, `Funct` = 100000, `PC` = 0, `PCPlus4` = 4, `InstrValid` high in cycle 3.
  - Second transfer: `Op` = 100011, `PC` = 4.
- Backpressure: hold `InstrReady` = 0 for 5 cycles in HOLD → `Instr`/`PC` stable, `InstrValid` = 1, no `imem_req`. `InstrReady` = 1 → next request for `PC` + 4 in the following cycle.
- Redirect in WAIT: L = 3, assert `Redirect` with `RedirectPC` = 0x0000_0042 one cycle after the request.
  - The response 0xDEAD_BEEF never appears on `Instr`.
  - The next request is at 0x0000_0040 in the cycle after `imem_rvalid`.
- Redirect in HOLD with `InstrReady` = 0, `RedirectPC` = 0x100 → `InstrValid` = 0 next cycle, then `imem_addr` = 0x100.
- Wrap: `Redirect` to 0xFFFF_FFFC → fetched `PC` = 0xFFFF_FFFC, `PCPlus4` = 0, next `imem_addr` = 0.
- Reset mid-WAIT: assert `reset` for 1 cycle while waiting, and let the old `imem_rvalid` arrive in the IDLE cycle.
  - The response is ignored and `InstrValid` stays 0.
  - Fetch restarts at `RESET_PC`.
